inst_rom_loader: RTL and testbench

- Instruction-memory responder on the far side of the core's instruction-fetch port: takes rom_ce/rom_addr from the core and returns the 32-bit instruction in the same cycle.
- Before fetch is allowed, the program is streamed in over a valid/ready load port.
- boot_done_o gates fetch and is used at the top level to release the core.
- Replaces a hand-preloaded ROM so the same bitstream can run different programs.

---
 rtl/inst_rom_loader.sv | 101 ++++++++++
 tb/tb_inst_rom_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
// Instruction memory: a program is streamed in over a valid/ready port (LOAD), then served to the core (RUN).
// Fetch is combinational (zero latency). ld_ready_o is low in RUN, where load words are ignored.
module inst_rom_loader #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic [31:0]           addr_i,
    output logic [31:0]           inst_o,
    input  logic                  ld_valid_i,
    input  logic [31:0]           ld_data_i,
    input  logic                  ld_last_i,
    output logic                  ld_ready_o,
    input  logic                  reload_i,
    output logic                  boot_done_o,
    output logic [DEPTH_LOG2:0]   ld_count_o,
    output logic                  load_ovf_o,
    output logic                  fetch_err_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  ferr_q, ferr_d;
    logic [31:0]           mem [DEPTH];

    logic                  mem_we;
    logic                  valid_fetch;
    logic [DEPTH_LOG2-1:0] idx;

    assign idx         = addr_i[DEPTH_LOG2+1:2];
    assign ld_ready_o  = (state_q == ST_LOAD);
    assign boot_done_o = (state_q == ST_RUN);

    // Reads only happen in RUN and writes only in LOAD, so no read/write collision exists.
    assign valid_fetch = ce_i & boot_done_o & (addr_i[1:0] == 2'b00)
                       & (addr_i[31:DEPTH_LOG2+2] == '0)
                       & ({1'b0, idx} < count_q);
    assign inst_o      = valid_fetch ? mem[idx] : 32'h0;

    // A reload in the same cycle as a load word discards that word.
    assign mem_we      = ld_valid_i & ld_ready_o & ~reload_i;

    assign ld_count_o  = count_q;
    assign load_ovf_o  = ovf_q;
    assign fetch_err_o = ferr_q;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        ferr_d  = ferr_q | (ce_i & boot_done_o & ~valid_fetch);
        if (reload_i) begin
            state_d = ST_LOAD;
            wptr_d  = '0;
            count_d = '0;
        end else if (mem_we) begin
            wptr_d  = wptr_q + DEPTH_LOG2'(1);
            count_d = count_q + (DEPTH_LOG2+1)'(1);
            if (ld_last_i) begin
                state_d = ST_RUN;
            end else if (wptr_q == DEPTH_LOG2'(DEPTH - 1)) begin
                // Full without a last marker: stop rather than wrap onto word 0.
                state_d = ST_RUN;
                ovf_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOAD;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q] <= ld_data_i;
        end
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: reference model of the loaded image plus a fetch scoreboard.
module tb_inst_rom_loader;
    localparam int DL2   = 10;
    localparam int DEPTH = 1 << DL2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] inst_o;
    logic        ld_valid_i = 1'b0;
    logic [31:0] ld_data_i = '0;
    logic        ld_last_i = 1'b0;
    logic        ld_ready_o;
    logic        reload_i = 1'b0;
    logic        boot_done_o;
    logic [DL2:0] ld_count_o;
    logic        load_ovf_o;
    logic        fetch_err_o;

    inst_rom_loader #(.DEPTH_LOG2(DL2)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce_i),
        .addr_i      (addr_i),
        .inst_o      (inst_o),
        .ld_valid_i  (ld_valid_i),
        .ld_data_i   (ld_data_i),
        .ld_last_i   (ld_last_i),
        .ld_ready_o  (ld_ready_o),
        .reload_i    (reload_i),
        .boot_done_o (boot_done_o),
        .ld_count_o  (ld_count_o),
        .load_ovf_o  (load_ovf_o),
        .fetch_err_o (fetch_err_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] exp_q [$];
    logic [31:0] mdl_mem [DEPTH];
    int          mdl_cnt  = 0;
    bit          mdl_run  = 1'b0;
    bit          mdl_ovf  = 1'b0;
    bit          mdl_ferr = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit mdl_valid(input bit ce, input logic [31:0] a);
        return ce && mdl_run && (a[1:0] == 2'b00) && (a[31:12] == 20'h0)
               && (int'(a[11:2]) < mdl_cnt);
    endfunction

    task automatic check_flags(input string tag);
        check_val({tag, ".boot"},  {31'b0, boot_done_o}, {31'b0, mdl_run});
        check_val({tag, ".ready"}, {31'b0, ld_ready_o},  {31'b0, !mdl_run});
        check_val({tag, ".count"}, {21'b0, ld_count_o},  32'(mdl_cnt));
        check_val({tag, ".ovf"},   {31'b0, load_ovf_o},  {31'b0, mdl_ovf});
        check_val({tag, ".ferr"},  {31'b0, fetch_err_o}, {31'b0, mdl_ferr});
    endtask

    // Drive one fetch at a negedge; the instruction must be there in the same cycle.
    task automatic do_fetch(input string tag, input bit ce, input logic [31:0] a);
        logic [31:0] e;
        bit v;
        @(negedge clk);
        ce_i   = ce;
        addr_i = a;
        v = mdl_valid(ce, a);
        exp_q.push_back(v ? mdl_mem[a[11:2]] : 32'h0);
        #1;
        e = exp_q.pop_front();
        check_val(tag, inst_o, e);
        if (ce && mdl_run && !v) mdl_ferr = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        ce_i       = 1'b0;
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
        reload_i   = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] d, input bit last, input bit chk);
        @(negedge clk);
        ld_valid_i = 1'b1;
        ld_data_i  = d;
        ld_last_i  = last;
        if (chk) begin
            #1;
            check_val("ld_ready", {31'b0, ld_ready_o}, 32'd1);
            check_val("boot_pre", {31'b0, boot_done_o}, 32'd0);
        end
        @(posedge clk);
        if (!mdl_run) begin
            mdl_mem[mdl_cnt] = d;
            mdl_cnt++;
            if (last) mdl_run = 1'b1;
            else if (mdl_cnt == DEPTH) begin
                mdl_run = 1'b1;
                mdl_ovf = 1'b1;
            end
        end
    endtask

    task automatic do_reload(input bit with_word, input logic [31:0] d);
        @(negedge clk);
        reload_i   = 1'b1;
        ld_valid_i = with_word;
        ld_data_i  = d;
        ld_last_i  = 1'b1;
        @(posedge clk);
        mdl_run = 1'b0;
        mdl_cnt = 0;
    endtask

    logic [31:0] prog1 [4];
    logic [31:0] prog5 [5];

    initial begin
        prog1[0] = 32'h34010001; prog1[1] = 32'h34020002;
        prog1[2] = 32'h00221821; prog1[3] = 32'h00000000;
        for (int i = 0; i < 5; i++) prog5[i] = 32'h1111_0000 + 32'(i * 3);

        // Reset state
        #2;
        check_flags("rst");
        check_val("rst.inst", inst_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // 1: four-word program
        for (int i = 0; i < 4; i++) load_word(prog1[i], i == 3, 1'b1);
        idle();
        check_flags("t1");
        do_fetch("t1.fetch8", 1'b1, 32'h8);
        do_fetch("t1.fetch0", 1'b1, 32'h0);
        idle();
        check_flags("t1.post");

        // 2: disabled, out-of-range and misaligned fetches
        do_fetch("t2.ce0", 1'b0, 32'h0);
        idle();
        check_val("t2.ce0_noerr", {31'b0, fetch_err_o}, 32'd0);
        do_fetch("t2.idx4", 1'b1, 32'h10);
        idle();
        check_val("t2.err_set", {31'b0, fetch_err_o}, 32'd1);
        do_fetch("t2.misalign", 1'b1, 32'h6);
        do_fetch("t2.high", 1'b1, 32'h0000_1000);
        idle();
        check_flags("t2");

        // 3: overflow stream with valid toggling
        do_reload(1'b0, 32'h0);
        idle();
        check_flags("t3.reload");
        for (int i = 0; i < 2 * DEPTH; i++) begin
            @(negedge clk);
            ld_valid_i = (i % 2 == 0);
            ld_data_i  = ld_valid_i ? 32'hA000_0000 + 32'(i / 2) : 32'hBAD0_0000 + 32'(i);
            ld_last_i  = 1'b0;
            @(posedge clk);
            if (ld_valid_i && !mdl_run) begin
                mdl_mem[mdl_cnt] = ld_data_i;
                mdl_cnt++;
                if (mdl_cnt == DEPTH) begin
                    mdl_run = 1'b1;
                    mdl_ovf = 1'b1;
                end
            end
        end
        idle();
        check_flags("t3");
        do_fetch("t3.w0", 1'b1, 32'h0);
        do_fetch("t3.w1", 1'b1, 32'h4);
        do_fetch("t3.wlast", 1'b1, 32'hFFC);
        load_word(32'h5555_5555, 1'b0, 1'b0);
        idle();
        check_flags("t3.run_ignore");

        // 4: reload collides with a load word; the word must be dropped
        do_reload(1'b1, 32'hDEADBEEF);
        idle();
        check_flags("t4.reload");
        load_word(32'h24080005, 1'b1, 1'b1);
        idle();
        check_flags("t4.loaded");
        do_fetch("t4.f0", 1'b1, 32'h0);
        do_fetch("t4.f4_masked", 1'b1, 32'h4);
        idle();
        check_flags("t4.post");

        // 5: asynchronous reset mid-load
        do_reload(1'b0, 32'h0);
        idle();
        for (int i = 0; i < 2; i++) load_word(prog5[i], 1'b0, 1'b1);
        idle();
        check_val("t5.mid_count", {21'b0, ld_count_o}, 32'd2);
        #2;
        rst = 1'b0;
        mdl_cnt = 0; mdl_run = 1'b0; mdl_ovf = 1'b0; mdl_ferr = 1'b0;
        #1;
        check_flags("t5.async");
        check_val("t5.async_inst", inst_o, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_flags("t5.release");
        for (int i = 0; i < 5; i++) load_word(prog5[i], i == 4, 1'b1);
        idle();
        check_flags("t5.loaded");
        for (int i = 0; i < 5; i++) do_fetch("t5.fetch", 1'b1, 32'(i * 4));
        do_fetch("t5.beyond", 1'b1, 32'h14);
        idle();
        check_flags("t5.post");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
